// File: rtl/mul_rr_arbiter_if.sv
// Requester and multiplier-datapath signals shared by mul_rr_arbiter.
// slave: arbiter view; master: requester/datapath view.
interface mul_rr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 16
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] op_a_bus;
  logic [N*W-1:0] op_b_bus;
  logic [N-1:0]   ack;
  logic [W-1:0]   result;
  logic           busy;
  logic [IW-1:0]  grant_id;
  logic [W-1:0]   dp_data_in;
  logic           dp_ldA;
  logic           dp_ldB;
  logic           dp_ldP;
  logic           dp_clrP;
  logic           dp_decB;
  logic           dp_eqz;
  logic [W-1:0]   dp_product;

  modport slave (
    input  req, op_a_bus, op_b_bus, dp_eqz, dp_product,
    output ack, result, busy, grant_id,
           dp_data_in, dp_ldA, dp_ldB, dp_ldP, dp_clrP, dp_decB
  );

  modport master (
    output req, op_a_bus, op_b_bus, dp_eqz, dp_product,
    input  ack, result, busy, grant_id,
           dp_data_in, dp_ldA, dp_ldB, dp_ldP, dp_clrP, dp_decB
  );
endinterface

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter sequencing a shared repeated-addition multiplier datapath.
// Optional MUL_OPERAND_SWAP_EN: put min(A,B) in the datapath counter to shorten latency.
module mul_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 16
) (
  input logic              clk,
  input logic              rst_n,
  mul_rr_arbiter_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [N-1:0]  ack_q, ack_d;

  logic [IW-1:0] win;
  logic          win_vld;
  logic [IW:0]   idx_w;
  logic [W-1:0]  sel_a, sel_b;

  // First set request searching upward from the pointer, wrapping at N.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx_w   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_w = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx_w >= (IW+1)'(N)) idx_w = idx_w - (IW+1)'(N);
      if (!win_vld && bus.req[idx_w[IW-1:0]]) begin
        win_vld = 1'b1;
        win     = idx_w[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (win == IW'(k)) begin
        sel_a = bus.op_a_bus[k*W +: W];
        sel_b = bus.op_b_bus[k*W +: W];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_d        = grant_q;
    a_d            = a_q;
    b_d            = b_q;
    res_d          = res_q;
    ack_d          = '0;
    bus.dp_data_in = '0;
    bus.dp_ldA     = 1'b0;
    bus.dp_ldB     = 1'b0;
    bus.dp_ldP     = 1'b0;
    bus.dp_clrP    = 1'b0;
    bus.dp_decB    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win;
          a_d     = sel_a;
          b_d     = sel_b;
`ifdef MUL_OPERAND_SWAP_EN
          if (sel_b > sel_a) begin
            a_d = sel_b;
            b_d = sel_a;
          end
`endif
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        bus.dp_data_in = a_q;
        bus.dp_ldA     = 1'b1;
        state_d        = LOAD_B;
      end
      LOAD_B: begin
        bus.dp_data_in = b_q;
        bus.dp_ldB     = 1'b1;
        bus.dp_clrP    = 1'b1;
        state_d        = CALC;
      end
      CALC: begin
        if (!bus.dp_eqz) begin
          bus.dp_ldP  = 1'b1;
          bus.dp_decB = 1'b1;
        end else begin
          res_d   = bus.dp_product;
          ack_d   = N'(1) << grant_q;
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = (grant_q == IW'(N-1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    bus.ack      = ack_q;
    bus.result   = res_q;
    bus.busy     = (state_q != IDLE);
    bus.grant_id = grant_q;
  end
endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Directed bench for mul_rr_arbiter with a behavioural repeated-addition datapath.
// Swap-test latency expectation follows MUL_OPERAND_SWAP_EN.
module tb_mul_rr_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  mul_rr_arbiter_if #(.N(N), .W(W)) bus ();

  mul_rr_arbiter #(.N(N), .W(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] dp_a = '0;
  logic [W-1:0] dp_b = '0;
  logic [W-1:0] dp_p = '0;

  always @(posedge clk) begin
    if (bus.dp_ldA) dp_a <= bus.dp_data_in;
    if (bus.dp_ldB) dp_b <= bus.dp_data_in;
    else if (bus.dp_decB) dp_b <= dp_b - 1'b1;
    if (bus.dp_clrP) dp_p <= '0;
    else if (bus.dp_ldP) dp_p <= dp_p + dp_a;
  end

  assign bus.dp_eqz     = (dp_b == '0);
  assign bus.dp_product = dp_p;

  int cnt_lda = 0, cnt_ldb = 0, cnt_clrp = 0, cnt_ldp = 0, cnt_decb = 0;
  always @(negedge clk) begin
    cnt_lda  <= cnt_lda  + int'(bus.dp_ldA);
    cnt_ldb  <= cnt_ldb  + int'(bus.dp_ldB);
    cnt_clrp <= cnt_clrp + int'(bus.dp_clrP);
    cnt_ldp  <= cnt_ldp  + int'(bus.dp_ldP);
    cnt_decb <= cnt_decb + int'(bus.dp_decB);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int e);
    e = 0;
    while (bus.ack == '0 && e < 3000) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  // Single request: edge 0 samples req, ack expected after edge exp_lat.
  task automatic run_op(input string tag, input int id, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input int exp_lat);
    int e;
    int lda0, ldb0, clrp0, ldp0, decb0;
    logic [N-1:0] r;
    lda0 = cnt_lda; ldb0 = cnt_ldb; clrp0 = cnt_clrp; ldp0 = cnt_ldp; decb0 = cnt_decb;
    bus.op_a_bus[id*W +: W] = a;
    bus.op_b_bus[id*W +: W] = b;
    r = '0;
    r[id] = 1'b1;
    bus.req = r;
    @(posedge clk);
    #1;
    bus.req = '0;
    bus.op_a_bus = '1;
    bus.op_b_bus = '1;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_grant"}, 32'(bus.grant_id), 32'(id));
    e = 0;
    while (bus.ack == '0 && e < 3000) begin
      @(posedge clk);
      #1;
      e++;
    end
    check({tag, "_latency"}, 32'(e), 32'(exp_lat));
    check({tag, "_ack"}, 32'(bus.ack), 32'(r));
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    @(posedge clk);
    #1;
    check({tag, "_ack_1cyc"}, 32'(bus.ack), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_result_hold"}, 32'(bus.result), 32'(exp_res));
    check({tag, "_n_ldA"}, 32'(cnt_lda - lda0), 32'd1);
    check({tag, "_n_ldB"}, 32'(cnt_ldb - ldb0), 32'd1);
    check({tag, "_n_clrP"}, 32'(cnt_clrp - clrp0), 32'd1);
    check({tag, "_n_ldP"}, 32'(cnt_ldp - ldp0), 32'(exp_lat - 3));
    check({tag, "_n_decB"}, 32'(cnt_decb - decb0), 32'(exp_lat - 3));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 32'(bus.ack), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_grant"}, 32'(bus.grant_id), 32'd0);
    check({tag, "_dp"}, 32'({bus.dp_data_in, bus.dp_ldA, bus.dp_ldB, bus.dp_ldP,
                             bus.dp_clrP, bus.dp_decB}), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int e;
    int exp_swap_lat;
    bus.req      = '0;
    bus.op_a_bus = '0;
    bus.op_b_bus = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op("single", 0, 16'd17, 16'd5, 16'd85, 8);
    run_op("bzero", 0, 16'd1234, 16'd0, 16'd0, 3);

    // All four hold req: served in order 0..3, then the pointer wraps to 0.
    pulse_reset();
    bus.op_a_bus = {16'd8, 16'd6, 16'd4, 16'd2};
    bus.op_b_bus = {16'd9, 16'd7, 16'd5, 16'd3};
    bus.req = 4'hF;
    for (int i = 0; i < 4; i++) begin
      wait_ack(e);
      check($sformatf("rr%0d_ack", i), 32'(bus.ack), 32'(1 << i));
      check($sformatf("rr%0d_result", i), 32'(bus.result), 32'((2*i+2)*(2*i+3)));
      @(posedge clk);
      #1;
    end
    e = 0;
    while (!bus.busy && e < 10) begin
      @(posedge clk);
      #1;
      e++;
    end
    check("rr_wrap_busy", 32'(bus.busy), 32'd1);
    check("rr_wrap_grant", 32'(bus.grant_id), 32'd0);
    bus.req = '0;
    wait_ack(e);
    check("rr_wrap_result", 32'(bus.result), 32'd6);
    @(posedge clk);
    #1;
    check("rr_wrap_ack_clear", 32'(bus.ack), 32'd0);
    @(negedge clk);

    run_op("overflow", 3, 16'd300, 16'd300, 16'd24464, 303);

    // Reset in the middle of CALC aborts without ack.
    @(negedge clk);
    bus.op_a_bus[1*W +: W] = 16'd17;
    bus.op_b_bus[1*W +: W] = 16'd100;
    bus.req = 4'b0010;
    @(posedge clk);
    #1;
    bus.req = '0;
    repeat (20) @(posedge clk);
    #1;
    check("midreset_pre_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    check("midreset_no_ack", 32'(bus.ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_reset", 2, 16'd3, 16'd4, 16'd12, 7);

`ifdef MUL_OPERAND_SWAP_EN
    exp_swap_lat = 6;
`else
    exp_swap_lat = 1003;
`endif
    @(negedge clk);
    run_op("swap", 1, 16'd3, 16'd1000, 16'd3000, exp_swap_lat);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
